mole_grid_renderer: RTL and testbench

//  Parametrised VGA renderer for the whack-a-mole screen. Generates its own sync

---
 rtl/mole_grid_renderer.sv | 217 +++++++++++++++++++++
 tb/tb_mole_grid_renderer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mole_grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : mole_grid_renderer
//  Purpose  : VGA renderer for the whack-a-mole screen. Generates sync timing,
//             draws a grid of slots with one highlighted mole, and blinks the
//             slots green/red for hit/miss feedback.
//  Revision : 1.0 - initial release
// ============================================================================
module mole_grid_renderer #(
  parameter int H_TOTAL      = 800,
  parameter int H_PULSE      = 96,
  parameter int H_BP         = 144,
  parameter int H_FP         = 784,
  parameter int V_TOTAL      = 521,
  parameter int V_PULSE      = 2,
  parameter int V_BP         = 31,
  parameter int V_FP         = 511,
  parameter int GRID_COLS    = 3,
  parameter int GRID_ROWS    = 3,
  parameter int IDX_W        = 3,
  parameter int GRID_X0      = 120,
  parameter int GRID_Y0      = 40,
  parameter int SLOT_SIZE    = 100,
  parameter int SLOT_GAP     = 50,
  parameter int MOLE_INSET   = 20,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_FRAMES = 5
) (
  input  logic             clk_pixel,
  input  logic             rst,
  input  logic [IDX_W-1:0] mole_pos_i,
  input  logic             mole_en_i,
  input  logic             flash_ok_i,
  input  logic             flash_bad_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [2:0]       red_o,
  output logic [2:0]       green_o,
  output logic [1:0]       blue_o,
  output logic             frame_start_o,
  output logic             flash_busy_o
);

  localparam int c_HC_W    = $clog2(H_TOTAL);
  localparam int c_VC_W    = $clog2(V_TOTAL);
  localparam int c_PITCH   = SLOT_SIZE + SLOT_GAP;
  localparam int c_OFF_W   = $clog2(c_PITCH + 1);
  localparam int c_X_START = H_BP + GRID_X0;
  localparam int c_Y_START = V_BP + GRID_Y0;
  localparam int c_FC_W    = $clog2(FLASH_FRAMES + 1);
  localparam int c_BC_W    = $clog2(BLINK_FRAMES + 1);
  localparam logic [IDX_W:0] c_NUM_SLOTS = (IDX_W+1)'(GRID_COLS * GRID_ROWS);

  localparam logic [7:0] c_SLOT_RGB = 8'b111_111_11;
  localparam logic [7:0] c_MOLE_RGB = 8'b111_111_00;
  localparam logic [7:0] c_OK_RGB   = 8'b000_111_00;
  localparam logic [7:0] c_BAD_RGB  = 8'b111_000_00;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OK = 2'd1, ST_BAD = 2'd2} state_t;

  logic [c_HC_W-1:0]  hc_q, hc_d;
  logic [c_VC_W-1:0]  vc_q, vc_d;
  logic               w_h_wrap, w_v_wrap;
  // Column tracker: valid flag, column number and offset inside the slot pitch
  logic               xv_q, xv_d;
  logic [IDX_W-1:0]   xcol_q, xcol_d;
  logic [c_OFF_W-1:0] xoff_q, xoff_d;
  // Row tracker: rowbase is row*GRID_COLS, kept by repeated addition
  logic               yv_q, yv_d;
  logic [IDX_W-1:0]   yrow_q, yrow_d, ybase_q, ybase_d;
  logic [c_OFF_W-1:0] yoff_q, yoff_d;
  logic               mole_vis_q;
  logic [IDX_W-1:0]   mole_idx_q;
  logic               s1_active_q, s1_slot_q, s1_mole_q, s1_hs_q, s1_vs_q;
  logic [7:0]         rgb_q, w_rgb;
  logic               hsync_q, vsync_q, frame_start_q;
  logic               w_active, w_slot, w_mole;
  logic [IDX_W-1:0]   w_idx;
  state_t             state_q;
  logic [c_FC_W-1:0]  frame_cnt_q;
  logic [c_BC_W-1:0]  blink_cnt_q;
  logic               phase_q, flash_busy_q;

  // Next-state for the raster counters and the incremental slot trackers
  always_comb begin
    w_h_wrap = (hc_q == c_HC_W'(H_TOTAL - 1));
    w_v_wrap = (vc_q == c_VC_W'(V_TOTAL - 1));
    hc_d     = w_h_wrap ? '0 : hc_q + 1'b1;
    vc_d     = vc_q;
    if (w_h_wrap) vc_d = w_v_wrap ? '0 : vc_q + 1'b1;

    xv_d = xv_q; xcol_d = xcol_q; xoff_d = xoff_q;
    if (hc_d == c_HC_W'(c_X_START)) begin
      xv_d = 1'b1; xcol_d = '0; xoff_d = '0;
    end else if (w_h_wrap) begin
      xv_d = 1'b0;
    end else if (xv_q) begin
      if (xoff_q == c_OFF_W'(c_PITCH - 1)) begin
        xoff_d = '0;
        if (xcol_q == IDX_W'(GRID_COLS - 1)) xv_d = 1'b0;
        else xcol_d = xcol_q + 1'b1;
      end else begin
        xoff_d = xoff_q + 1'b1;
      end
    end

    yv_d = yv_q; yrow_d = yrow_q; ybase_d = ybase_q; yoff_d = yoff_q;
    if (w_h_wrap) begin
      if (vc_d == c_VC_W'(c_Y_START)) begin
        yv_d = 1'b1; yrow_d = '0; ybase_d = '0; yoff_d = '0;
      end else if (w_v_wrap) begin
        yv_d = 1'b0;
      end else if (yv_q) begin
        if (yoff_q == c_OFF_W'(c_PITCH - 1)) begin
          yoff_d = '0;
          if (yrow_q == IDX_W'(GRID_ROWS - 1)) begin
            yv_d = 1'b0;
          end else begin
            yrow_d  = yrow_q + 1'b1;
            ybase_d = ybase_q + IDX_W'(GRID_COLS);
          end
        end else begin
          yoff_d = yoff_q + 1'b1;
        end
      end
    end
  end

  // Region decode for the current count and colour selection for stage 2
  always_comb begin
    w_active = (hc_q >= c_HC_W'(H_BP)) && (hc_q < c_HC_W'(H_FP)) &&
               (vc_q >= c_VC_W'(V_BP)) && (vc_q < c_VC_W'(V_FP));
    w_slot   = xv_q && yv_q && (xoff_q < c_OFF_W'(SLOT_SIZE)) &&
               (yoff_q < c_OFF_W'(SLOT_SIZE));
    w_idx    = ybase_q + xcol_q;
    w_mole   = w_slot && mole_vis_q && (w_idx == mole_idx_q) &&
               (xoff_q >= c_OFF_W'(MOLE_INSET)) &&
               (xoff_q < c_OFF_W'(SLOT_SIZE - MOLE_INSET)) &&
               (yoff_q >= c_OFF_W'(MOLE_INSET)) &&
               (yoff_q < c_OFF_W'(SLOT_SIZE - MOLE_INSET));

    w_rgb = 8'd0;
    if (s1_active_q && (s1_mole_q || s1_slot_q)) begin
      if ((state_q != ST_IDLE) && phase_q)
        w_rgb = (state_q == ST_BAD) ? c_BAD_RGB : c_OK_RGB;
      else
        w_rgb = s1_mole_q ? c_MOLE_RGB : c_SLOT_RGB;
    end
  end

  // Counters, trackers and the two-stage output pipeline
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      hc_q <= '0; vc_q <= '0;
      xv_q <= (c_X_START == 0); xcol_q <= '0; xoff_q <= '0;
      yv_q <= (c_Y_START == 0); yrow_q <= '0; ybase_q <= '0; yoff_q <= '0;
      s1_active_q <= 1'b0; s1_slot_q <= 1'b0; s1_mole_q <= 1'b0;
      s1_hs_q <= 1'b1; s1_vs_q <= 1'b1;
      rgb_q <= '0; hsync_q <= 1'b1; vsync_q <= 1'b1; frame_start_q <= 1'b0;
    end else begin
      hc_q <= hc_d; vc_q <= vc_d;
      xv_q <= xv_d; xcol_q <= xcol_d; xoff_q <= xoff_d;
      yv_q <= yv_d; yrow_q <= yrow_d; ybase_q <= ybase_d; yoff_q <= yoff_d;
      s1_active_q <= w_active; s1_slot_q <= w_slot; s1_mole_q <= w_mole;
      s1_hs_q <= (hc_q >= c_HC_W'(H_PULSE));
      s1_vs_q <= (vc_q >= c_VC_W'(V_PULSE));
      rgb_q <= w_rgb; hsync_q <= s1_hs_q; vsync_q <= s1_vs_q;
      frame_start_q <= w_h_wrap && w_v_wrap;
    end
  end

  // Mole position is captured once per frame so a frame never tears
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      mole_vis_q <= 1'b0; mole_idx_q <= '0;
    end else if (frame_start_q) begin
      mole_vis_q <= mole_en_i && ({1'b0, mole_pos_i} < c_NUM_SLOTS);
      mole_idx_q <= mole_pos_i;
    end
  end

  // Flash FSM: events restart the flash, frame starts advance blink and duration
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE; frame_cnt_q <= '0; blink_cnt_q <= '0;
      phase_q <= 1'b0; flash_busy_q <= 1'b0;
    end else if (flash_bad_i || flash_ok_i) begin
      state_q      <= flash_bad_i ? ST_BAD : ST_OK;
      frame_cnt_q  <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      flash_busy_q <= 1'b1;
    end else if (frame_start_q && (state_q != ST_IDLE)) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
      if (blink_cnt_q == c_BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      if (frame_cnt_q == c_FC_W'(FLASH_FRAMES - 1)) begin
        state_q      <= ST_IDLE;
        flash_busy_q <= 1'b0;
      end
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign red_o         = rgb_q[7:5];
  assign green_o       = rgb_q[4:2];
  assign blue_o        = rgb_q[1:0];
  assign frame_start_o = frame_start_q;
  assign flash_busy_o  = flash_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mole_grid_renderer
//  Purpose  : Self-checking bench for mole_grid_renderer using a reduced
//             raster (32x24) so many frames fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mole_grid_renderer;

  localparam int HT = 32, HP = 3, HB = 5, HF = 30;
  localparam int VT = 24, VP = 2, VB = 3, VF = 22;
  localparam int FR = HT * VT;
  localparam int IW = 4;

  logic          clk_pixel = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] mole_pos = '0;
  logic          mole_en = 1'b0, flash_ok = 1'b0, flash_bad = 1'b0;
  logic          hsync, vsync, frame_start, flash_busy;
  logic [2:0]    red, green;
  logic [1:0]    blue;

  mole_grid_renderer #(
    .H_TOTAL(HT), .H_PULSE(HP), .H_BP(HB), .H_FP(HF),
    .V_TOTAL(VT), .V_PULSE(VP), .V_BP(VB), .V_FP(VF),
    .GRID_COLS(3), .GRID_ROWS(3), .IDX_W(IW),
    .GRID_X0(2), .GRID_Y0(1), .SLOT_SIZE(5), .SLOT_GAP(2), .MOLE_INSET(1),
    .FLASH_FRAMES(6), .BLINK_FRAMES(2)
  ) u_dut (
    .clk_pixel(clk_pixel), .rst(rst),
    .mole_pos_i(mole_pos), .mole_en_i(mole_en),
    .flash_ok_i(flash_ok), .flash_bad_i(flash_bad),
    .hsync_o(hsync), .vsync_o(vsync),
    .red_o(red), .green_o(green), .blue_o(blue),
    .frame_start_o(frame_start), .flash_busy_o(flash_busy)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Cycles since reset release; equals the expected raster count position
  int cyc = 0;
  always @(posedge clk_pixel or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    int         due;
    string      name;
    logic [7:0] rgb;
    bit         chk_busy;
    logic       busy;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: sync/frame_start against the raster model in the first frame,
  // and scoreboard entries when their due cycle arrives
  always @(negedge clk_pixel) begin
    if (!rst) begin
      if (cyc >= 2 && cyc <= FR + 1) begin
        check("hsync", 32'(hsync), 32'(((cyc - 2) % HT) >= HP));
        check("vsync", 32'(vsync), 32'((((cyc - 2) / HT) % VT) >= VP));
      end
      if (cyc >= 1 && cyc <= FR + 1)
        check("frame_start", 32'(frame_start), 32'(cyc == FR));
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        if (mon_e.due != cyc) check({mon_e.name, "_late"}, 32'(cyc), 32'(mon_e.due));
        check(mon_e.name, 32'({red, green, blue}), 32'(mon_e.rgb));
        if (mon_e.chk_busy) check({mon_e.name, "_busy"}, 32'(flash_busy), 32'(mon_e.busy));
      end
    end
  end

  task automatic goto_hv(input int frame, input int hc, input int vc);
    int target;
    int limit;
    target = frame * FR + vc * HT + hc;
    limit  = target - cyc + 4;
    for (int n = 0; n < limit && cyc < target; n++) @(negedge clk_pixel);
    if (cyc != target) begin
      total++; bad++;
      $display("FAIL reach: got cyc %0d want %0d", cyc, target);
    end
  endtask

  task automatic probe(input int frame, input int ax, input int ay, input string nm,
                       input logic [7:0] rgb, input bit cb, input logic b);
    goto_hv(frame, ax + HB, ay + VB);
    sbq.push_back('{due: cyc + 2, name: nm, rgb: rgb, chk_busy: cb, busy: b});
  endtask

  task automatic pulse(input logic ok, input logic bd);
    flash_ok = ok; flash_bad = bd;
    @(negedge clk_pixel);
    flash_ok = 1'b0; flash_bad = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_busy"}, 32'(flash_busy), 32'd0);
  endtask

  // Blink sequence seen one to six frame starts after a flash_ok event
  logic [7:0] blink_rgb [6] = '{8'h1C, 8'hFF, 8'hFF, 8'h1C, 8'h1C, 8'hFF};
  logic       blink_bsy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    repeat (3) @(negedge clk_pixel);
    rst = 1'b0;
    check_reset_vals("reset");
    mole_en = 1'b1; mole_pos = 4'd4;

    // Frame 0: mole not yet latched
    probe(0, 11, 10, "f0_no_latch", 8'hFF, 1'b1, 1'b0);
    // Frame 1: mole at slot 4, geometry edges
    probe(1, 4, 3, "f1_slot0", 8'hFF, 1'b0, 1'b0);
    goto_hv(1, 2, 13);
    sbq.push_back('{due: cyc + 2, name: "f1_hblank", rgb: 8'h00, chk_busy: 1'b0, busy: 1'b0});
    probe(1, 7, 10, "f1_gap_left", 8'h00, 1'b0, 1'b0);
    probe(1, 9, 10, "f1_slot4_edge", 8'hFF, 1'b0, 1'b0);
    probe(1, 11, 10, "f1_mole4", 8'hFC, 1'b0, 1'b0);
    probe(1, 13, 10, "f1_slot4_right", 8'hFF, 1'b0, 1'b0);
    probe(1, 14, 10, "f1_gap_right", 8'h00, 1'b0, 1'b0);
    goto_hv(1, 2, 14);
    mole_pos = 4'd0;
    probe(1, 11, 11, "f1_mole_hold", 8'hFC, 1'b0, 1'b0);
    probe(1, 11, 13, "f1_row_gap", 8'h00, 1'b0, 1'b0);
    // Frame 2: mole moved to slot 0
    probe(2, 4, 3, "f2_mole0", 8'hFC, 1'b0, 1'b0);
    probe(2, 11, 10, "f2_slot4", 8'hFF, 1'b0, 1'b0);
    goto_hv(2, 0, 16);
    mole_pos = 4'd8;
    // Frame 3: last slot
    probe(3, 4, 3, "f3_slot0", 8'hFF, 1'b0, 1'b0);
    probe(3, 18, 17, "f3_mole8", 8'hFC, 1'b0, 1'b0);
    goto_hv(3, 0, 22);
    mole_pos = 4'd9;
    // Frame 4: out-of-range index draws no mole
    probe(4, 4, 3, "f4_pos9_s0", 8'hFF, 1'b0, 1'b0);
    probe(4, 11, 10, "f4_pos9_s4", 8'hFF, 1'b0, 1'b0);
    probe(4, 18, 17, "f4_pos9_s8", 8'hFF, 1'b0, 1'b0);
    goto_hv(4, 0, 22);
    mole_pos = 4'd4;

    // Frame 5: green flash
    goto_hv(5, 4, 3);
    pulse(1'b1, 1'b0);
    probe(5, 7, 10, "f5_bg", 8'h00, 1'b0, 1'b0);
    probe(5, 9, 10, "f5_ok_slot", 8'h1C, 1'b1, 1'b1);
    probe(5, 11, 10, "f5_ok_mole", 8'h1C, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      probe(6 + i, 9, 10, $sformatf("ok_f%0d", 6 + i), blink_rgb[i], 1'b1, blink_bsy[i]);

    // Frame 12: simultaneous events give red
    goto_hv(12, 4, 3);
    pulse(1'b1, 1'b1);
    probe(12, 11, 10, "f12_bad", 8'hE0, 1'b1, 1'b1);
    probe(13, 11, 10, "f13_bad", 8'hE0, 1'b1, 1'b1);
    probe(14, 11, 10, "f14_bad_off", 8'hFC, 1'b1, 1'b1);
    // Frame 15: flash_ok during BAD restarts a full green flash
    goto_hv(15, 4, 3);
    pulse(1'b1, 1'b0);
    probe(15, 9, 10, "f15_ok", 8'h1C, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      probe(16 + i, 9, 10, $sformatf("rs_f%0d", 16 + i), blink_rgb[i], 1'b1, blink_bsy[i]);

    // Frame 22: reset in the middle of a line with a flash in progress
    goto_hv(22, 10, 0);
    pulse(1'b1, 1'b0);
    goto_hv(22, 4, 1);
    check("pre_rst_hsync", 32'(hsync), 32'd0);
    check("pre_rst_vsync", 32'(vsync), 32'd0);
    check("pre_rst_busy", 32'(flash_busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk_pixel);
    rst = 1'b0;
    check_reset_vals("rerel");
    probe(0, 11, 10, "r0_no_latch", 8'hFF, 1'b1, 1'b0);
    probe(1, 11, 10, "r1_mole4", 8'hFC, 1'b1, 1'b0);

    repeat (4) @(negedge clk_pixel);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
